seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, slot advance rate; DIV = CLK_HZ/SCAN_HZ clocks per slot, DIV >= 4.
REQ-003 Parameter DEAD_CYC, default 16, anti-ghost blank cycles at slot start; 0 <= DEAD_CYC < DIV.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 load  input  1  one-cycle strobe; captures digits_in, dp_in, blank_in and blink_in.
REQ-007 digits_in  input  32  nibble i (bits 4i+3:4i) is the hex value for tube i, i = 0..7.
REQ-008 dp_in  input  8  bit i lights the decimal point of tube i.
REQ-009 blank_in  input  8  bit i forces tube i dark.
REQ-010 blink_in  input  8  bit i makes tube i blink.
REQ-011 blink_tick  input  1  one-cycle pulse that toggles the blink phase, normally 1 Hz.
REQ-012 digit1  output  8  segments for tubes 0-3, active-high, {dp,g,f,e,d,c,b,a}.
REQ-013 digit2  output  8  segments for tubes 4-7, same encoding.
REQ-014 tube_sel  output  8  tube enables, active-high; bit i = tube i.
REQ-015 frame_done  output  1  one-cycle pulse when the slot wraps from 3 to 0.

Function
REQ-016 Shadow registers shall capture all load-side inputs on the clk edge where load=1; load=0 shall hold them.
REQ-017 Prescaler shall count 0..DIV-1 and wrap; at terminal count DIV-1, slot (2 bits) shall advance 0->1->2->3->0.
REQ-018 In slot s, tube_sel shall enable tube s and tube s+4 at the same time; all other bits shall be 0.
REQ-019 In slot s, digit1 shall decode shadow nibble s and digit2 shall decode shadow nibble s+4.
REQ-020 Decode table (hex, bits 6:0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; bit 7 = shadow dp of that tube.
REQ-021 When the prescaler value is < DEAD_CYC, tube_sel shall be 8'h00; segments shall already show the new slot's values.
REQ-022 A tube shall be dark (its tube_sel bit 0 and its segment bus 8'h00) when its shadow blank bit is 1, or when its shadow blink bit is 1 and blink phase is 1.
REQ-023 blink_tick shall toggle blink phase on the same edge it is sampled; a load does not change the phase.
REQ-024 All outputs shall be registered, with 1-cycle latency from internal state (prescaler, slot, shadow, phase) to outputs; a load at edge N shall be visible at the outputs from edge N+1.
REQ-025 Load and slot advance on the same edge: the new slot shall display the newly loaded values from the next edge.
REQ-026 frame_done shall be 1 for exactly the one cycle after the 3->0 wrap; the pulse period is 4*DIV cycles.

Reset
REQ-027 rst low shall asynchronously clear the prescaler, slot, blink phase and the shadow digits, dp and blink registers, and set shadow blank to 8'hFF.
REQ-028 rst low shall drive digit1, digit2, tube_sel and frame_done to 0.
REQ-029 After rst is released, scanning shall restart at slot 0, prescaler 0, and the display shall stay dark until the first load.
REQ-030 rst asserted mid-slot or mid-dead-time shall abort the scan immediately, with no partial output.

Structure
REQ-031 Shared package seg_pkg shall hold the 16-entry segment table, the blank pattern 8'h00 and the slot width constant.
REQ-032 Sub-module seg7_decode (combinational, nibble + dp -> 8-bit segments) shall be instantiated twice, once for each group.

Verification (bench: CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, DEAD_CYC=2)
REQ-033 Reset then load digits_in=32'h76543210, blank_in=0 -> tube_sel cycles 11h,22h,44h,88h; digit1 = 3F,06,5B,4F; digit2 = 66,6D,7D,07; each slot 10 cycles, first 2 cycles with tube_sel=00.
REQ-034 No load after reset -> tube_sel and digits stay 00 for at least 3 full frames; frame_done pulses every 40 cycles.
REQ-035 blink_in=01h, dp_in=80h, one blink_tick -> tube 0 dark in slot 0 (tube_sel=10h, digit1=00); digit2 in slot 3 shows bit7 set; a second blink_tick restores tube 0.
REQ-036 load at the prescaler terminal count of slot 1, with digits_in=32'hFFFFFFFF -> slot 2 outputs digit1=71, digit2=71 from its first cycle on.
REQ-037 rst pulsed low during slot 2, after its dead time -> all outputs go to 0 immediately; after release, slot 0 and a dark display until the next load.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
//   SLOT_W    : width of the scan slot counter (4 slots, 2 tubes per slot)
//   SEG_BLANK : segment pattern for a dark tube
//   SEG_TABLE : hex nibble -> segments {g,f,e,d,c,b,a}, active-high
package seg_pkg;

  localparam int SLOT_W = 2;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Index 15 is leftmost in the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-7-segment decoder.
//   nibble : hex digit to display
//   dp     : decimal point request
//   seg    : segments {dp,g,f,e,d,c,b,a}, active-high
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {dp, SEG_TABLE[nibble]};

endmodule

// File: rtl/seg_scan_driver.sv
// Scan driver for eight 7-segment tubes arranged as two groups of four.
// Each slot lights tube s (group 1, digit1) and tube s+4 (group 2, digit2)
// together; a short blanking window at the start of every slot keeps the
// previous slot's segments from ghosting onto the newly selected tubes.
//   clk, rst          : clock, asynchronous active-low reset
//   load              : strobe capturing digits_in/dp_in/blank_in/blink_in
//   digits_in         : nibble i = hex value of tube i
//   dp_in, blank_in   : per-tube decimal point / force-dark
//   blink_in          : per-tube blink enable
//   blink_tick        : toggles the blink phase
//   digit1, digit2    : registered segment buses for tubes 0-3 / 4-7
//   tube_sel          : registered tube enables, bit i = tube i
//   frame_done        : one-cycle pulse after the slot wraps from 3 to 0
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DEAD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  blink_in,
  input  logic        blink_tick,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  tube_sel,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TC   = PW'(DIV - 1);
  localparam logic [PW-1:0] DEAD = PW'(DEAD_CYC);

  logic [PW-1:0]     presc;
  logic [SLOT_W-1:0] slot;
  logic              phase;
  logic [31:0]       sh_digits;
  logic [7:0]        sh_dp;
  logic [7:0]        sh_blank;
  logic [7:0]        sh_blink;

  logic              tc;
  logic [2:0]        lo_idx;
  logic [2:0]        hi_idx;
  logic [7:0]        seg_lo;
  logic [7:0]        seg_hi;
  logic              dark_lo;
  logic              dark_hi;
  logic [7:0]        sel_nxt;
  logic [7:0]        d1_nxt;
  logic [7:0]        d2_nxt;

  assign tc     = (presc == TC);
  assign lo_idx = {1'b0, slot};
  assign hi_idx = {1'b1, slot};

  // Reset leaves every tube blanked so nothing lights until the first load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      slot      <= '0;
      phase     <= 1'b0;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= 8'hFF;
      sh_blink  <= '0;
    end else begin
      presc <= tc ? '0 : presc + PW'(1);
      if (tc) slot <= slot + SLOT_W'(1);
      if (blink_tick) phase <= ~phase;
      if (load) begin
        sh_digits <= digits_in;
        sh_dp     <= dp_in;
        sh_blank  <= blank_in;
        sh_blink  <= blink_in;
      end
    end
  end

  seg7_decode u_dec_lo (
    .nibble (sh_digits[{lo_idx, 2'b00} +: 4]),
    .dp     (sh_dp[lo_idx]),
    .seg    (seg_lo)
  );

  seg7_decode u_dec_hi (
    .nibble (sh_digits[{hi_idx, 2'b00} +: 4]),
    .dp     (sh_dp[hi_idx]),
    .seg    (seg_hi)
  );

  assign dark_lo = sh_blank[lo_idx] | (sh_blink[lo_idx] & phase);
  assign dark_hi = sh_blank[hi_idx] | (sh_blink[hi_idx] & phase);

  // Segments switch to the new slot right away; only the tube enables wait
  // out the blanking window.
  always_comb begin
    sel_nxt = '0;
    if (presc >= DEAD) begin
      sel_nxt[lo_idx] = ~dark_lo;
      sel_nxt[hi_idx] = ~dark_hi;
    end
    d1_nxt = dark_lo ? SEG_BLANK : seg_lo;
    d2_nxt = dark_hi ? SEG_BLANK : seg_hi;
  end

  // frame_done is raised on the wrap edge itself, so it is high for the
  // single cycle that follows the 3->0 transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit1     <= SEG_BLANK;
      digit2     <= SEG_BLANK;
      tube_sel   <= '0;
      frame_done <= 1'b0;
    end else begin
      digit1     <= d1_nxt;
      digit2     <= d2_nxt;
      tube_sel   <= sel_nxt;
      frame_done <= tc && (slot == '1);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIV = 10, DEAD_CYC = 2).
// Output sample k is taken on the falling edge after the k-th rising edge
// since the last reset release; that sample reflects the scan position
// prescaler = (k-1)%10, slot = ((k-1)/10)%4.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        blink_tick = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic [7:0]  blink_in = '0;
  logic [7:0]  digit1;
  logic [7:0]  digit2;
  logic [7:0]  tube_sel;
  logic        frame_done;

  seg_scan_driver #(.CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .blink_in   (blink_in),
    .blink_tick (blink_tick),
    .digit1     (digit1),
    .digit2     (digit2),
    .tube_sel   (tube_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  int n_pass = 0;
  int n_total = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int         at;
    logic [7:0] ts;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       fd;
    string      name;
  } exp_t;

  exp_t sb[$];
  event sample_ev;

  logic [7:0] ts_tab [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
  logic [7:0] d1_tab [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
  logic [7:0] d2_tab [4] = '{8'h66, 8'h6D, 8'h7D, 8'h07};

  task automatic expect_at(input int k, input logic [7:0] ts, input logic [7:0] d1,
                           input logic [7:0] d2, input logic fd, input string name);
    exp_t e;
    e.at = base + k;
    e.ts = ts;
    e.d1 = d1;
    e.d2 = d2;
    e.fd = fd;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_k(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic pulse_load(input int k, input logic [31:0] dg, input logic [7:0] dp,
                            input logic [7:0] bl, input logic [7:0] bk);
    wait_k(k - 1);
    digits_in = dg;
    dp_in     = dp;
    blank_in  = bl;
    blink_in  = bk;
    load      = 1'b1;
    wait_k(k);
    load      = 1'b0;
  endtask

  task automatic pulse_tick(input int k);
    wait_k(k - 1);
    blink_tick = 1'b1;
    wait_k(k);
    blink_tick = 1'b0;
  endtask

  // Monitor: compares whichever expectations are due at this sample point.
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_total++;
        if (e.at != cyc)
          $display("FAIL %s: sample missed (due cycle %0d, now %0d)", e.name, e.at, cyc);
        else if ({tube_sel, digit1, digit2, frame_done} !== {e.ts, e.d1, e.d2, e.fd})
          $display("FAIL %s @%0d: got tube_sel=%h digit1=%h digit2=%h frame_done=%b, want tube_sel=%h digit1=%h digit2=%h frame_done=%b",
                   e.name, cyc - base, tube_sel, digit1, digit2, frame_done, e.ts, e.d1, e.d2, e.fd);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks still queued", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held: everything 0.
    expect_at(2, 8'h00, 8'h00, 8'h00, 1'b0, "reset_hold");
    wait_k(3);
    rst  = 1'b1;
    base = cyc;

    // No load yet: dark display, frame_done every 40 cycles.
    expect_at(5,   8'h00, 8'h00, 8'h00, 1'b0, "dark_s0");
    expect_at(15,  8'h00, 8'h00, 8'h00, 1'b0, "dark_s1");
    expect_at(39,  8'h00, 8'h00, 8'h00, 1'b0, "fd_before");
    expect_at(40,  8'h00, 8'h00, 8'h00, 1'b1, "fd_1");
    expect_at(41,  8'h00, 8'h00, 8'h00, 1'b0, "fd_after");
    expect_at(80,  8'h00, 8'h00, 8'h00, 1'b1, "fd_2");
    expect_at(120, 8'h00, 8'h00, 8'h00, 1'b1, "fd_3");
    expect_at(125, 8'h00, 8'h00, 8'h00, 1'b0, "dark_f4");

    // Digits 0..7 loaded at the start of a frame (edge 160).
    for (int s = 0; s < 4; s++) begin
      expect_at(161 + 10 * s, 8'h00, d1_tab[s], d2_tab[s], 1'b0, "scan_dead");
      expect_at(163 + 10 * s, ts_tab[s], d1_tab[s], d2_tab[s], 1'b0, "scan_on");
      expect_at(170 + 10 * s, ts_tab[s], d1_tab[s], d2_tab[s], (s == 3), "scan_end");
    end

    // Blink on tube 0, dp on tube 7; ticks at edges 245 and 285.
    expect_at(244, 8'h11, 8'h3F, 8'h66, 1'b0, "blink_off0");
    expect_at(245, 8'h11, 8'h3F, 8'h66, 1'b0, "blink_pre_tick");
    expect_at(246, 8'h10, 8'h00, 8'h66, 1'b0, "blink_dark");
    expect_at(275, 8'h88, 8'h4F, 8'h87, 1'b0, "dp_tube7");
    expect_at(285, 8'h10, 8'h00, 8'h66, 1'b0, "blink_dark2");
    expect_at(286, 8'h11, 8'h3F, 8'h66, 1'b0, "blink_restored");
    expect_at(295, 8'h22, 8'h06, 8'h6D, 1'b0, "blink_other");

    // All-F load on the slot 1 -> 2 advance edge (380).
    expect_at(380, 8'h22, 8'h06, 8'h6D, 1'b0, "tc_old");
    expect_at(381, 8'h00, 8'h71, 8'h71, 1'b0, "tc_new_first");
    expect_at(383, 8'h44, 8'h71, 8'h71, 1'b0, "tc_new_on");
    expect_at(390, 8'h44, 8'h71, 8'h71, 1'b0, "tc_new_end");

    // Mid-slot-2 reset after the blanking window.
    expect_at(425, 8'h44, 8'h71, 8'h71, 1'b0, "pre_abort");

    pulse_load(160, 32'h76543210, 8'h00, 8'h00, 8'h00);
    pulse_load(240, 32'h76543210, 8'h80, 8'h00, 8'h01);
    pulse_tick(245);
    pulse_tick(285);
    pulse_load(380, 32'hFFFFFFFF, 8'h00, 8'h00, 8'h00);

    wait_k(425);
    #1 rst = 1'b0;
    expect_at(425, 8'h00, 8'h00, 8'h00, 1'b0, "abort_now");
    expect_at(426, 8'h00, 8'h00, 8'h00, 1'b0, "abort_hold1");
    expect_at(427, 8'h00, 8'h00, 8'h00, 1'b0, "abort_hold2");
    #1 -> sample_ev;
    wait_k(428);
    rst  = 1'b1;
    base = cyc;

    // After the abort: slot 0, dark until the next load.
    expect_at(5,   8'h00, 8'h00, 8'h00, 1'b0, "rst2_dark_s0");
    expect_at(15,  8'h00, 8'h00, 8'h00, 1'b0, "rst2_dark_s1");
    expect_at(39,  8'h00, 8'h00, 8'h00, 1'b0, "rst2_fd_before");
    expect_at(40,  8'h00, 8'h00, 8'h00, 1'b1, "rst2_fd_1");
    expect_at(41,  8'h00, 8'h00, 8'h00, 1'b0, "rst2_fd_after");
    expect_at(80,  8'h00, 8'h00, 8'h00, 1'b1, "rst2_fd_2");
    expect_at(83,  8'h11, 8'h3F, 8'h66, 1'b0, "rst2_reload_s0");
    expect_at(113, 8'h88, 8'h4F, 8'h07, 1'b0, "rst2_reload_s3");

    pulse_load(80, 32'h76543210, 8'h00, 8'h00, 8'h00);
    wait_k(115);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_total++;
      $display("FAIL %s: never sampled (due cycle %0d, now %0d)", e.name, e.at, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
